// File: rtl/shared_pkg.sv
// Shared types and constants for the AES-APB-UART bridge.
// Serializer state encoding and AES block geometry.
package shared_pkg;

  localparam int AES_BLK_W     = 128;
  localparam int BYTES_PER_BLK = 16;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    START,
    WAIT
  } ser_state_e;

endpackage

// File: rtl/ser_block_fifo.sv
// Synchronous block FIFO, power-of-two depth.
// Pointers wrap naturally; full/empty come from the registered count.
module ser_block_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // Qualify requests and advance pointers/count
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  // Pointer and count registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; contents are meaningless once count is reset
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/aes_tx_serializer.sv
// AES ciphertext block buffer feeding the UART one byte at a time.
// One tx_start per byte, waits for tx_done, watchdog aborts stalls.
module aes_tx_serializer
  import shared_pkg::*;
#(
  parameter int DEPTH          = 2,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                   PCLK,
  input  logic                   PRESET,
  input  logic                   blk_valid,
  input  logic [AES_BLK_W-1:0]   blk_data,
  output logic                   blk_ready,
  output logic                   tx_start,
  output logic [7:0]             tx_byte,
  input  logic                   tx_done,
  output logic [$clog2(DEPTH):0] fill_level,
  output logic                   busy,
  output logic                   timeout_err
);

  localparam int WD_W =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST =
    WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [3:0] LAST_IDX = 4'(BYTES_PER_BLK - 1);

  ser_state_e           state_q, state_d;
  logic [AES_BLK_W-1:0] shreg_q, shreg_d;
  logic [3:0]           idx_q, idx_d;
  logic [WD_W-1:0]      wd_q, wd_d;
  logic [7:0]           byte_q, byte_d;
  logic                 err_q, err_d;

  logic                 fifo_push, fifo_pop;
  logic                 fifo_full, fifo_empty;
  logic [AES_BLK_W-1:0] fifo_head;
  logic                 last_byte, wd_hit;

  assign fifo_push = blk_valid && !fifo_full;
  assign blk_ready = !fifo_full;
  assign last_byte = (idx_q == LAST_IDX);
  assign wd_hit    = (TIMEOUT_CYCLES != 0) && (wd_q == WD_LAST);

  assign tx_byte     = byte_q;
  assign timeout_err = err_q;
  assign busy        = (state_q != IDLE);

  ser_block_fifo #(
    .WIDTH (AES_BLK_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (PCLK),
    .rst   (PRESET),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (blk_data),
    .head  (fifo_head),
    .count (fill_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // State, shift register, byte counter, watchdog and flags
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q <= IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
      wd_q    <= '0;
      byte_q  <= 8'h00;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      wd_q    <= wd_d;
      byte_q  <= byte_d;
      err_q   <= err_d;
    end
  end

  // Next-state: tx_done wins over a watchdog expiry in the same cycle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!fifo_empty) state_d = LOAD;
      LOAD:    state_d = START;
      START:   state_d = WAIT;
      WAIT: begin
        if (tx_done)     state_d = last_byte ? IDLE : START;
        else if (wd_hit) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs and datapath; tx_byte is loaded on entry to START
  always_comb begin
    shreg_d  = shreg_q;
    idx_d    = idx_q;
    wd_d     = wd_q;
    byte_d   = byte_q;
    err_d    = err_q;
    tx_start = 1'b0;
    fifo_pop = 1'b0;
    unique case (state_q)
      LOAD: begin
        fifo_pop = 1'b1;
        shreg_d  = fifo_head;
        idx_d    = '0;
        byte_d   = fifo_head[AES_BLK_W-1 -: 8];
      end
      START: begin
        tx_start = 1'b1;
        wd_d     = '0;
      end
      WAIT: begin
        if (tx_done) begin
          if (!last_byte) begin
            shreg_d = {shreg_q[AES_BLK_W-9:0], 8'h00};
            idx_d   = idx_q + 4'd1;
            byte_d  = shreg_q[AES_BLK_W-9 -: 8];
          end
        end else if (wd_hit) begin
          err_d = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule
